// File: rtl/index_y_sequencer_if.sv
// ---------------------------------------------------------------------------
// index_y_sequencer_if
// Bundles the op handshake and the result/strobe outputs of the Y-index
// sequencer.
//   master : control-FSM side. Drives op_valid/op_code/operand/A_in/Y_cur and
//            observes op_ready plus all results, strobes and flags.
//   slave  : the sequencer itself.
// Signals:
//   op_valid, op_ready      op handshake (accept on a rising edge when both 1)
//   op_code[2:0]            000 LDY,001 INY,010 DEY,011 TAY,100 TYA,101 CPY,
//                           110 STY,111 illegal
//   operand, A_in, Y_cur    op sources
//   IN_Y / load_Y           next Y value and its write strobe
//   A_out / load_A          accumulator value and its write strobe (TYA)
//   mem_data / mem_we       store data and memory write strobe (STY)
//   flag_N/Z/C, flag_nz_we, flag_c_we   status flag values and update strobes
//   done, op_err            completion pulse, illegal-op indication
// ---------------------------------------------------------------------------
interface index_y_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             op_valid;
    logic             op_ready;
    logic [2:0]       op_code;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] A_in;
    logic [WIDTH-1:0] Y_cur;
    logic [WIDTH-1:0] IN_Y;
    logic             load_Y;
    logic [WIDTH-1:0] A_out;
    logic             load_A;
    logic [WIDTH-1:0] mem_data;
    logic             mem_we;
    logic             flag_N;
    logic             flag_Z;
    logic             flag_C;
    logic             flag_nz_we;
    logic             flag_c_we;
    logic             done;
    logic             op_err;

    modport master (
        output op_valid, op_code, operand, A_in, Y_cur,
        input  op_ready, IN_Y, load_Y, A_out, load_A, mem_data, mem_we,
               flag_N, flag_Z, flag_C, flag_nz_we, flag_c_we, done, op_err
    );

    modport slave (
        input  op_valid, op_code, operand, A_in, Y_cur,
        output op_ready, IN_Y, load_Y, A_out, load_A, mem_data, mem_we,
               flag_N, flag_Z, flag_C, flag_nz_we, flag_c_we, done, op_err
    );
endinterface

// File: rtl/index_y_sequencer.sv
// ---------------------------------------------------------------------------
// index_y_sequencer
// Executes the 6502 Y-index micro-operations (LDY, INY, DEY, TAY, TYA, CPY,
// STY). An op is captured in IDLE, its result computed in EXEC, presented with
// one-cycle write strobes in WRITE and acknowledged with a done pulse in DONE.
// Every output is a flop, so data is stable across the whole WRITE cycle and
// the Y register's falling-edge sample sees a settled value.
// Ports:
//   FSM_Signal  clock, all state changes on its rising edge
//   reset_IDX   asynchronous active-high reset; aborts any op in flight
//   bus         index_y_sequencer_if.slave (handshake, data, strobes, flags)
// ---------------------------------------------------------------------------
module index_y_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic                 FSM_Signal,
    input  logic                 reset_IDX,
    index_y_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] OP_LDY = 3'd0;
    localparam logic [2:0] OP_INY = 3'd1;
    localparam logic [2:0] OP_DEY = 3'd2;
    localparam logic [2:0] OP_TAY = 3'd3;
    localparam logic [2:0] OP_TYA = 3'd4;
    localparam logic [2:0] OP_CPY = 3'd5;
    localparam logic [2:0] OP_STY = 3'd6;

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_s;
    logic             accept_s;

    // Captured op; the live inputs are never looked at after the accept edge.
    logic [2:0]       op_r;
    logic [WIDTH-1:0] operand_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] y_r;

    // Decoded result of the captured op.
    logic [WIDTH-1:0] res_s;
    logic             wr_y_s;
    logic             wr_a_s;
    logic             wr_m_s;
    logic             nz_we_s;
    logic             c_we_s;
    logic             c_s;
    logic             illegal_s;

    // Next values and registers for every output.
    logic             op_ready_s, op_ready_r;
    logic [WIDTH-1:0] in_y_s,     in_y_r;
    logic [WIDTH-1:0] a_out_s,    a_out_r;
    logic [WIDTH-1:0] mem_data_s, mem_data_r;
    logic             load_y_s,   load_y_r;
    logic             load_a_s,   load_a_r;
    logic             mem_we_s,   mem_we_r;
    logic             flag_n_s,   flag_n_r;
    logic             flag_z_s,   flag_z_r;
    logic             flag_c_s,   flag_c_r;
    logic             nz_we_o_s,  nz_we_r;
    logic             c_we_o_s,   c_we_r;
    logic             done_s,     done_r;
    logic             op_err_s,   op_err_r;

    assign accept_s = (state_r == ST_IDLE) && bus.op_valid;

    // State register.
    always_ff @(posedge FSM_Signal or posedge reset_IDX) begin
        if (reset_IDX) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: fixed four-phase sequence, waits only in IDLE.
    always_comb begin
        state_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (bus.op_valid) begin
                    state_s = ST_EXEC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EXEC:  state_s = ST_WRITE;
            ST_WRITE: state_s = ST_DONE;
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Op capture on the accept edge.
    always_ff @(posedge FSM_Signal or posedge reset_IDX) begin
        if (reset_IDX) begin
            op_r      <= 3'd0;
            operand_r <= ZERO;
            a_r       <= ZERO;
            y_r       <= ZERO;
        end else if (accept_s) begin
            op_r      <= bus.op_code;
            operand_r <= bus.operand;
            a_r       <= bus.A_in;
            y_r       <= bus.Y_cur;
        end else begin
            op_r      <= op_r;
            operand_r <= operand_r;
            a_r       <= a_r;
            y_r       <= y_r;
        end
    end

    // Result and write-target decode of the captured op (modulo arithmetic).
    always_comb begin
        res_s     = ZERO;
        wr_y_s    = 1'b0;
        wr_a_s    = 1'b0;
        wr_m_s    = 1'b0;
        nz_we_s   = 1'b0;
        c_we_s    = 1'b0;
        c_s       = 1'b0;
        illegal_s = 1'b0;
        case (op_r)
            OP_LDY: begin res_s = operand_r;   wr_y_s = 1'b1; nz_we_s = 1'b1; end
            OP_INY: begin res_s = y_r + ONE;   wr_y_s = 1'b1; nz_we_s = 1'b1; end
            OP_DEY: begin res_s = y_r - ONE;   wr_y_s = 1'b1; nz_we_s = 1'b1; end
            OP_TAY: begin res_s = a_r;         wr_y_s = 1'b1; nz_we_s = 1'b1; end
            OP_TYA: begin res_s = y_r;         wr_a_s = 1'b1; nz_we_s = 1'b1; end
            OP_CPY: begin
                // Carry is "no borrow": set when Y >= operand as unsigned.
                res_s   = y_r - operand_r;
                c_s     = (y_r >= operand_r);
                nz_we_s = 1'b1;
                c_we_s  = 1'b1;
            end
            OP_STY: begin res_s = y_r;         wr_m_s = 1'b1; end
            default: begin illegal_s = 1'b1; end
        endcase
    end

    // Output next-values: strobes are loaded only when leaving EXEC, so they
    // are high exactly during WRITE; data and flags hold between ops.
    always_comb begin
        op_ready_s = (state_s == ST_IDLE);
        done_s     = (state_r == ST_WRITE);
        op_err_s   = (state_r == ST_WRITE) && illegal_s;
        if (state_r == ST_EXEC) begin
            load_y_s   = wr_y_s;
            load_a_s   = wr_a_s;
            mem_we_s   = wr_m_s;
            nz_we_o_s  = nz_we_s;
            c_we_o_s   = c_we_s;
            in_y_s     = wr_y_s ? res_s : in_y_r;
            a_out_s    = wr_a_s ? res_s : a_out_r;
            mem_data_s = wr_m_s ? res_s : mem_data_r;
            flag_n_s   = nz_we_s ? res_s[WIDTH-1] : 1'b0;
            flag_z_s   = nz_we_s ? (res_s == ZERO) : 1'b0;
            flag_c_s   = c_we_s ? c_s : 1'b0;
        end else begin
            load_y_s   = 1'b0;
            load_a_s   = 1'b0;
            mem_we_s   = 1'b0;
            nz_we_o_s  = 1'b0;
            c_we_o_s   = 1'b0;
            in_y_s     = in_y_r;
            a_out_s    = a_out_r;
            mem_data_s = mem_data_r;
            flag_n_s   = flag_n_r;
            flag_z_s   = flag_z_r;
            flag_c_s   = flag_c_r;
        end
    end

    // Output registers; reset drops every strobe immediately.
    always_ff @(posedge FSM_Signal or posedge reset_IDX) begin
        if (reset_IDX) begin
            op_ready_r <= 1'b1;
            in_y_r     <= ZERO;
            a_out_r    <= ZERO;
            mem_data_r <= ZERO;
            load_y_r   <= 1'b0;
            load_a_r   <= 1'b0;
            mem_we_r   <= 1'b0;
            flag_n_r   <= 1'b0;
            flag_z_r   <= 1'b0;
            flag_c_r   <= 1'b0;
            nz_we_r    <= 1'b0;
            c_we_r     <= 1'b0;
            done_r     <= 1'b0;
            op_err_r   <= 1'b0;
        end else begin
            op_ready_r <= op_ready_s;
            in_y_r     <= in_y_s;
            a_out_r    <= a_out_s;
            mem_data_r <= mem_data_s;
            load_y_r   <= load_y_s;
            load_a_r   <= load_a_s;
            mem_we_r   <= mem_we_s;
            flag_n_r   <= flag_n_s;
            flag_z_r   <= flag_z_s;
            flag_c_r   <= flag_c_s;
            nz_we_r    <= nz_we_o_s;
            c_we_r     <= c_we_o_s;
            done_r     <= done_s;
            op_err_r   <= op_err_s;
        end
    end

    assign bus.op_ready   = op_ready_r;
    assign bus.IN_Y       = in_y_r;
    assign bus.load_Y     = load_y_r;
    assign bus.A_out      = a_out_r;
    assign bus.load_A     = load_a_r;
    assign bus.mem_data   = mem_data_r;
    assign bus.mem_we     = mem_we_r;
    assign bus.flag_N     = flag_n_r;
    assign bus.flag_Z     = flag_z_r;
    assign bus.flag_C     = flag_c_r;
    assign bus.flag_nz_we = nz_we_r;
    assign bus.flag_c_we  = c_we_r;
    assign bus.done       = done_r;
    assign bus.op_err     = op_err_r;

endmodule

// File: tb/tb_index_y_sequencer.sv
// ---------------------------------------------------------------------------
// tb_index_y_sequencer
// Directed vector table, hand-written multi-cycle sequences (reset abort,
// back-to-back handshake) and random ops checked against an arithmetic model.
// ---------------------------------------------------------------------------
module tb_index_y_sequencer;

    logic clk;
    logic rst;

    index_y_sequencer_if #(.WIDTH(8)) bus ();

    index_y_sequencer #(.WIDTH(8)) dut (
        .FSM_Signal (clk),
        .reset_IDX  (rst),
        .bus        (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [2:0] op;
        logic [7:0] operand;
        logic [7:0] a;
        logic [7:0] y;
        logic       ly;
        logic       la;
        logic       we;
        logic       nzwe;
        logic       cwe;
        logic       err;
        logic [7:0] data;
        logic       n;
        logic       z;
        logic       c;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] strobes();
        return {bus.load_Y, bus.load_A, bus.mem_we, bus.flag_nz_we,
                bus.flag_c_we, bus.done, bus.op_err};
    endfunction

    function automatic vec_t mk(input logic [2:0] op, input logic [7:0] opd,
                                input logic [7:0] a, input logic [7:0] y,
                                input logic ly, input logic la, input logic we,
                                input logic nzwe, input logic cwe, input logic err,
                                input logic [7:0] data, input logic n,
                                input logic z, input logic c);
        vec_t v;
        v.op = op; v.operand = opd; v.a = a; v.y = y;
        v.ly = ly; v.la = la; v.we = we; v.nzwe = nzwe; v.cwe = cwe; v.err = err;
        v.data = data; v.n = n; v.z = z; v.c = c;
        return v;
    endfunction

    // Reference model: expected effect of one op, from plain integer arithmetic.
    function automatic vec_t model(input logic [2:0] op, input logic [7:0] opd,
                                   input logic [7:0] a, input logic [7:0] y);
        vec_t v;
        int   r;
        v = mk(op, opd, a, y, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        r = 0;
        case (op)
            3'd0: begin r = int'(opd);                   v.ly = 1'b1; v.nzwe = 1'b1; end
            3'd1: begin r = (int'(y) + 1) % 256;         v.ly = 1'b1; v.nzwe = 1'b1; end
            3'd2: begin r = (int'(y) + 255) % 256;       v.ly = 1'b1; v.nzwe = 1'b1; end
            3'd3: begin r = int'(a);                     v.ly = 1'b1; v.nzwe = 1'b1; end
            3'd4: begin r = int'(y);                     v.la = 1'b1; v.nzwe = 1'b1; end
            3'd5: begin
                r = (int'(y) - int'(opd) + 256) % 256;
                v.nzwe = 1'b1; v.cwe = 1'b1;
                v.c = (int'(y) >= int'(opd));
            end
            3'd6: begin r = int'(y);                     v.we = 1'b1; end
            default: begin v.err = 1'b1; end
        endcase
        v.data = 8'(r);
        if (v.nzwe) begin
            v.n = (r >= 128);
            v.z = (r == 0);
        end
        return v;
    endfunction

    // Busy-time noise: op_valid and source changes must all be ignored.
    task automatic noise();
        bus.op_valid = 1'($urandom_range(0, 1));
        bus.op_code  = 3'($urandom);
        bus.operand  = 8'($urandom);
        bus.A_in     = 8'($urandom);
        bus.Y_cur    = 8'($urandom);
    endtask

    task automatic chk_data(input string tag, input vec_t v);
        if (v.ly) chk({tag, ".IN_Y"}, 32'(bus.IN_Y), 32'(v.data));
        else if (v.la) chk({tag, ".A_out"}, 32'(bus.A_out), 32'(v.data));
        else if (v.we) chk({tag, ".mem_data"}, 32'(bus.mem_data), 32'(v.data));
    endtask

    // Runs one op starting at a negedge in IDLE; returns at the negedge of the
    // first IDLE cycle afterwards, so the next call is accepted at edge N+4.
    task automatic do_op(input vec_t v, input string tag);
        bus.op_code  = v.op;
        bus.operand  = v.operand;
        bus.A_in     = v.a;
        bus.Y_cur    = v.y;
        bus.op_valid = 1'b1;
        chk({tag, ".ready_before"}, 32'(bus.op_ready), 32'd1);
        @(negedge clk);                               // EXEC
        noise();
        chk({tag, ".exec_strobes"}, 32'(strobes()), 32'd0);
        chk({tag, ".exec_ready"}, 32'(bus.op_ready), 32'd0);
        @(negedge clk);                               // WRITE
        noise();
        chk({tag, ".write_strobes"}, 32'(strobes()),
            32'({v.ly, v.la, v.we, v.nzwe, v.cwe, 1'b0, 1'b0}));
        chk_data({tag, ".write"}, v);
        if (v.nzwe) chk({tag, ".NZ"}, 32'({bus.flag_N, bus.flag_Z}), 32'({v.n, v.z}));
        chk({tag, ".C"}, 32'(bus.flag_C), 32'(v.c));
        @(negedge clk);                               // DONE
        noise();
        chk({tag, ".done_strobes"}, 32'(strobes()), 32'({5'b00000, 1'b1, v.err}));
        chk({tag, ".done_ready"}, 32'(bus.op_ready), 32'd0);
        chk_data({tag, ".hold"}, v);
        @(negedge clk);                               // IDLE
        bus.op_valid = 1'b0;
        chk({tag, ".idle_strobes"}, 32'(strobes()), 32'd0);
        chk({tag, ".idle_ready"}, 32'(bus.op_ready), 32'd1);
    endtask

    vec_t table_v [10];
    vec_t rv;

    initial begin
        rst          = 1'b1;
        bus.op_valid = 1'b0;
        bus.op_code  = 3'd0;
        bus.operand  = 8'h00;
        bus.A_in     = 8'h00;
        bus.Y_cur    = 8'h00;

        //                op    opd    a      y      ly    la    we    nzwe  cwe   err   data   n     z     c
        table_v[0] = mk(3'd0, 8'h80, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0);
        table_v[1] = mk(3'd1, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        table_v[2] = mk(3'd2, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
        table_v[3] = mk(3'd3, 8'h11, 8'h7F, 8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0);
        table_v[4] = mk(3'd5, 8'h10, 8'h00, 8'h10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        table_v[5] = mk(3'd5, 8'h20, 8'h00, 8'h10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        table_v[6] = mk(3'd4, 8'h33, 8'h44, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        table_v[7] = mk(3'd6, 8'h01, 8'h02, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);
        table_v[8] = mk(3'd7, 8'hAA, 8'hBB, 8'hCC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        table_v[9] = mk(3'd5, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        chk("reset.ready", 32'(bus.op_ready), 32'd1);
        chk("reset.strobes", 32'(strobes()), 32'd0);
        chk("reset.data", 32'({bus.IN_Y, bus.A_out, bus.mem_data}), 32'd0);
        chk("reset.flags", 32'({bus.flag_N, bus.flag_Z, bus.flag_C}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors.
        for (int i = 0; i < 10; i++) begin
            do_op(table_v[i], $sformatf("vec%0d", i));
        end

        // Reset asserted in the middle of the WRITE cycle of LDY #$42.
        bus.op_code  = 3'd0;
        bus.operand  = 8'h42;
        bus.op_valid = 1'b1;
        @(negedge clk);                               // EXEC
        bus.op_valid = 1'b0;
        @(negedge clk);                               // WRITE
        chk("abort.load_before", 32'(bus.load_Y), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort.load_drop", 32'(bus.load_Y), 32'd0);
        chk("abort.data_clear", 32'(bus.IN_Y), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("abort.quiet%0d", i), 32'({strobes(), bus.op_ready}), 32'd1);
        end

        // Back-to-back: op_valid held high, second op only accepted at N+4.
        bus.op_code  = 3'd1;
        bus.Y_cur    = 8'h05;
        bus.op_valid = 1'b1;
        @(negedge clk);                               // after edge N: EXEC of INY
        bus.op_code  = 3'd0;
        bus.operand  = 8'h33;
        bus.Y_cur    = 8'h99;
        chk("b2b.ready_n1", 32'(bus.op_ready), 32'd0);
        @(negedge clk);                               // WRITE of INY
        chk("b2b.write1", 32'({bus.load_Y, bus.IN_Y}), 32'({1'b1, 8'h06}));
        @(negedge clk);                               // DONE of INY
        chk("b2b.done1", 32'({bus.done, bus.op_ready}), 32'({1'b1, 1'b0}));
        @(negedge clk);                               // IDLE, second op pending
        chk("b2b.ready_n4", 32'({bus.op_ready, bus.load_Y}), 32'({1'b1, 1'b0}));
        @(negedge clk);                               // after edge N+4: EXEC of LDY
        bus.op_valid = 1'b0;
        chk("b2b.accept2", 32'(bus.op_ready), 32'd0);
        @(negedge clk);
        chk("b2b.write2", 32'({bus.load_Y, bus.IN_Y}), 32'({1'b1, 8'h33}));
        @(negedge clk);
        chk("b2b.done2", 32'(bus.done), 32'd1);
        @(negedge clk);

        // Random ops against the model, with random idle gaps.
        for (int i = 0; i < 60; i++) begin
            rv = model(3'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            do_op(rv, $sformatf("rnd%0d_op%0d", i, rv.op));
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                chk($sformatf("rnd%0d.gap", i), 32'({strobes(), bus.op_ready}), 32'd1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
